// File: rtl/multicycle_adder.sv
// Multi-cycle add/subtract: DIGIT bits per clock through a ripple slice, carry registered between digits.
// Latency: start accepted at edge t -> busy in cycles t+1..t+N, done pulse in cycle t+N+1 (N = WIDTH/DIGIT).
// No backpressure: start is honoured only in IDLE/DONE and ignored (not queued) while RUN is active.
module multicycle_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    // Reject illegal parameter combinations at elaboration time.
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("multicycle_adder: WIDTH must be >= 2");
        end
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("multicycle_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] shadow;

    logic [DIGIT-1:0] slice_a;
    logic [DIGIT-1:0] slice_b;
    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;
    logic             rc;
    logic [WIDTH-1:0] shadow_nx;
    logic             last;

    assign slice_a = a_r[k*DIGIT +: DIGIT];
    assign slice_b = b_r[k*DIGIT +: DIGIT];
    assign last    = (k == K_LAST);

    // Ripple slice of DIGIT full adders; also exposes the carry into the slice's top bit,
    // which on the final digit is the carry into the result MSB used for signed overflow.
    always_comb begin
        rc         = carry;
        slice_sum  = '0;
        slice_cmsb = carry;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                slice_cmsb = rc;
            end
            slice_sum[i] = slice_a[i] ^ slice_b[i] ^ rc;
            rc           = (slice_a[i] & slice_b[i]) | (rc & (slice_a[i] ^ slice_b[i]));
        end
        slice_cout = rc;
    end

    // Shadow result with the current digit merged in, so the final digit lands in sum directly.
    always_comb begin
        shadow_nx                    = shadow;
        shadow_nx[k*DIGIT +: DIGIT]  = slice_sum;
    end

    // Control FSM and datapath registers; results only move on completion or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_r    <= '0;
            b_r    <= '0;
            carry  <= 1'b0;
            k      <= '0;
            shadow <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction as a + ~b + 1, with the borrow-in folded into the carry.
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    shadow <= shadow_nx;
                    carry  <= slice_cout;
                    if (last) begin
                        sum   <= shadow_nx;
                        cout  <= slice_cout;
                        ovf   <= slice_cmsb ^ slice_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: W=8 with DIGIT 1/2/4/8 and W=16 with DIGIT 4 side by side.
// Directed vectors with hand-computed results, plus random operands against an arithmetic model.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
module tb_multicycle_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;

    logic [7:0]  s8  [4];
    logic        bz8 [4];
    logic        dn8 [4];
    logic        co8 [4];
    logic        ov8 [4];
    logic [15:0] s16;
    logic        bz16, dn16, co16, ov16;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g8
        multicycle_adder #(.WIDTH(8), .DIGIT(1 << gi)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start),
            .a     (a[7:0]),
            .b     (b[7:0]),
            .cin   (cin),
            .sub   (sub),
            .busy  (bz8[gi]),
            .done  (dn8[gi]),
            .sum   (s8[gi]),
            .cout  (co8[gi]),
            .ovf   (ov8[gi])
        );
    end

    multicycle_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (bz16),
        .done  (dn16),
        .sum   (s16),
        .cout  (co16),
        .ovf   (ov16)
    );

    // Per-instance accessors: index 0..3 are W=8 with DIGIT 1,2,4,8; index 4 is W=16, DIGIT=4.
    function automatic int g_n(int i);
        return (i < 4) ? (8 >> i) : 4;
    endfunction
    function automatic int g_w(int i);
        return (i < 4) ? 8 : 16;
    endfunction
    function automatic logic [15:0] g_sum(int i);
        return (i < 4) ? {8'h00, s8[i]} : s16;
    endfunction
    function automatic logic g_busy(int i);
        return (i < 4) ? bz8[i] : bz16;
    endfunction
    function automatic logic g_done(int i);
        return (i < 4) ? dn8[i] : dn16;
    endfunction
    function automatic logic g_cout(int i);
        return (i < 4) ? co8[i] : co16;
    endfunction
    function automatic logic g_ovf(int i);
        return (i < 4) ? ov8[i] : ov16;
    endfunction

    // Reference arithmetic: returns {ovf, cout, sum[15:0]} for width w.
    function automatic logic [17:0] model(int w, logic [15:0] av, logic [15:0] bv,
                                          logic c, logic s);
        logic [16:0] mask;
        logic [16:0] am, bm, full;
        logic [15:0] sm;
        logic        co, ov;
        mask = (17'd1 << w) - 17'd1;
        am   = {1'b0, av} & mask;
        bm   = (s ? {1'b0, ~bv} : {1'b0, bv}) & mask;
        full = am + bm + {16'd0, c ^ s};
        sm   = full[15:0] & mask[15:0];
        co   = full[w];
        ov   = (am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]);
        return {ov, co, sm};
    endfunction

    // One operation on all instances: checks busy/done timing each cycle, result hold, and result.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic c, input logic s);
        logic [15:0] prev [5];
        logic [17:0] exp_r;
        for (int i = 0; i < 5; i++) prev[i] = g_sum(i);
        @(negedge clk);
        a = av; b = bv; cin = c; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (g_busy(i) !== (j <= g_n(i))) begin
                    bad++;
                    $display("FAIL busy dut%0d cycle%0d got=%b want=%b", i, j, g_busy(i), (j <= g_n(i)));
                end
                total++;
                if (g_done(i) !== (j == g_n(i) + 1)) begin
                    bad++;
                    $display("FAIL done dut%0d cycle%0d got=%b want=%b", i, j, g_done(i), (j == g_n(i) + 1));
                end
                if (j == 1) begin
                    total++;
                    if (g_sum(i) !== prev[i]) begin
                        bad++;
                        $display("FAIL hold dut%0d got=%h want=%h", i, g_sum(i), prev[i]);
                    end
                end
                if (j == g_n(i) + 1) begin
                    exp_r = model(g_w(i), av, bv, c, s);
                    total++;
                    if ({g_ovf(i), g_cout(i), g_sum(i)} !== exp_r) begin
                        bad++;
                        $display("FAIL result dut%0d a=%h b=%h cin=%b sub=%b got=%b/%b/%h want=%b/%b/%h",
                                 i, av, bv, c, s, g_ovf(i), g_cout(i), g_sum(i),
                                 exp_r[17], exp_r[16], exp_r[15:0]);
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({g_busy(i), g_done(i), g_cout(i), g_ovf(i), g_sum(i)} !== 20'd0) begin
                bad++;
                $display("FAIL reset dut%0d got=%b/%b/%b/%b/%h want=0", i,
                         g_busy(i), g_done(i), g_cout(i), g_ovf(i), g_sum(i));
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith();
        // FF + 01 wraps: sum 00, carry out, no signed overflow.
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        total++;
        if ({ov8[0], co8[0], s8[0]} !== {1'b0, 1'b1, 8'h00}) begin
            bad++; $display("FAIL ff_plus_1 got=%b/%b/%h want=0/1/00", ov8[0], co8[0], s8[0]);
        end
        run_op(16'h007F, 16'h0001, 1'b0, 1'b0);
        total++;
        if ({ov8[0], co8[0], s8[0]} !== {1'b1, 1'b0, 8'h80}) begin
            bad++; $display("FAIL 7f_plus_1 got=%b/%b/%h want=1/0/80", ov8[0], co8[0], s8[0]);
        end
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        total++;
        if ({ov8[0], co8[0], s8[0]} !== {1'b0, 1'b0, 8'hFE}) begin
            bad++; $display("FAIL 5_minus_7 got=%b/%b/%h want=0/0/fe", ov8[0], co8[0], s8[0]);
        end
        run_op(16'h0080, 16'h0001, 1'b0, 1'b1);
        total++;
        if ({ov8[0], co8[0], s8[0]} !== {1'b1, 1'b1, 8'h7F}) begin
            bad++; $display("FAIL 80_minus_1 got=%b/%b/%h want=1/1/7f", ov8[0], co8[0], s8[0]);
        end
        // DIGIT=4: 3C + C4 + 1 = 0x101.
        run_op(16'h003C, 16'h00C4, 1'b1, 1'b0);
        total++;
        if ({ov8[2], co8[2], s8[2]} !== {1'b0, 1'b1, 8'h01}) begin
            bad++; $display("FAIL d4_3c_c4 got=%b/%b/%h want=0/1/01", ov8[2], co8[2], s8[2]);
        end
        // 16-bit subtract with borrow-in: 1000 - 0001 - 1 = 0FFE, no borrow.
        run_op(16'h1000, 16'h0001, 1'b1, 1'b1);
        total++;
        if ({ov16, co16, s16} !== {1'b0, 1'b1, 16'h0FFE}) begin
            bad++; $display("FAIL w16_sub got=%b/%b/%h want=0/1/0ffe", ov16, co16, s16);
        end
    endtask

    task automatic test_ignore_start();
        int seen;
        seen = 0;
        @(negedge clk);
        a = 16'h0012; b = 16'h0034; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            if (j == 3) begin
                a = 16'h00AA; b = 16'h0055; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (dn8[0]) begin
                seen++;
                total++;
                if (j != 9 || s8[0] !== 8'h46) begin
                    bad++; $display("FAIL ignore_start cycle=%0d sum=%h want cycle=9 sum=46", j, s8[0]);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (seen != 1) begin
            bad++; $display("FAIL ignore_start_count got=%0d want=1", seen);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        a = 16'h0021; b = 16'h0011; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({g_busy(i), g_done(i), g_cout(i), g_ovf(i), g_sum(i)} !== 20'd0) begin
                bad++;
                $display("FAIL mid_reset dut%0d got=%b/%b/%b/%b/%h want=0", i,
                         g_busy(i), g_done(i), g_cout(i), g_ovf(i), g_sum(i));
            end
        end
        run_op(16'h0033, 16'h0044, 1'b1, 1'b0);
        total++;
        if (s8[0] !== 8'h78) begin
            bad++; $display("FAIL after_reset got=%h want=78", s8[0]);
        end
    endtask

    task automatic test_back_to_back();
        int last_d [5];
        int cnt [5];
        logic [17:0] exp_r;
        for (int i = 0; i < 5; i++) begin last_d[i] = -1; cnt[i] = 0; end
        @(negedge clk);
        a = 16'h9C5A; b = 16'h63B7; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        for (int j = 1; j <= 30; j++) begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (g_busy(i) && g_done(i)) begin
                    bad++; $display("FAIL overlap dut%0d cycle%0d got=busy&done want=exclusive", i, j);
                end
                if (g_done(i)) begin
                    cnt[i]++;
                    total++;
                    if (last_d[i] < 0 ? (j != g_n(i) + 1) : (j - last_d[i] != g_n(i) + 1)) begin
                        bad++;
                        $display("FAIL period dut%0d cycle%0d prev=%0d want_gap=%0d", i, j, last_d[i], g_n(i) + 1);
                    end
                    exp_r = model(g_w(i), a, b, cin, sub);
                    total++;
                    if ({g_ovf(i), g_cout(i), g_sum(i)} !== exp_r) begin
                        bad++; $display("FAIL b2b_result dut%0d got=%h want=%h", i, g_sum(i), exp_r[15:0]);
                    end
                    last_d[i] = j;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (cnt[0] != 3) begin
            bad++; $display("FAIL b2b_count dut0 got=%0d want=3", cnt[0]);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
